// File: rtl/key_entry_ctrl_pkg.sv
// Shared constants for the keypad time-entry controller.
// Holds the FSM state encoding, the entry timeout length, the largest
// accepted digit code and the hour/minute digit limits used to decide
// whether the four entered digits form a legal HH:MM value.
package key_entry_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTRY      = 3'd1,
        LOAD_ALARM = 3'd2,
        LOAD_TIME  = 3'd3,
        ERROR      = 3'd4
    } state_t;

    localparam logic [3:0] TIMEOUT_SECS    = 4'd10;
    localparam logic [3:0] MAX_DIGIT       = 4'd9;
    localparam logic [3:0] MAX_MS_HR       = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_20 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN      = 4'd5;
    localparam logic [2:0] FULL_DIGITS     = 3'd4;

    // Legal 24-hour HH:MM: hours 00-23, minutes 00-59 (ls_min is always 0-9).
    function automatic logic is_valid_time(input logic [3:0] ms_hr,
                                           input logic [3:0] ls_hr,
                                           input logic [3:0] ms_min);
        return (ms_hr <= MAX_MS_HR)
            && !((ms_hr == MAX_MS_HR) && (ls_hr > MAX_LS_HR_AT_20))
            && (ms_min <= MAX_MS_MIN);
    endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Four-digit entry buffer with time-validity check.
// Ports:
//   clock, reset         - system clock, asynchronous active-high reset
//   shift_en             - shift key in at ls_min, oldest digit drops off ms_hr
//   clear                - zero the buffer (wins over shift_en)
//   key                  - digit to shift in
//   ms_hr..ls_min        - buffered digits, most significant first
//   time_valid           - buffer currently holds a legal HH:MM
module key_shift_reg
    import key_entry_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       shift_en,
    input  logic       clear,
    input  logic [3:0] key,
    output logic [3:0] ms_hr,
    output logic [3:0] ls_hr,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic       time_valid
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ms_hr  <= '0;
            ls_hr  <= '0;
            ms_min <= '0;
            ls_min <= '0;
        end else if (clear) begin
            ms_hr  <= '0;
            ls_hr  <= '0;
            ms_min <= '0;
            ls_min <= '0;
        end else if (shift_en) begin
            ms_hr  <= ls_hr;
            ls_hr  <= ms_min;
            ms_min <= ls_min;
            ls_min <= key;
        end
    end

    assign time_valid = is_valid_time(ms_hr, ls_hr, ms_min);

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad time/alarm entry controller.
// Collects up to four digits, then commits them as alarm or current time on
// the matching button, rejecting short or illegal entries. An idle entry is
// abandoned after TIMEOUT_SECS one_second ticks without a digit.
// Ports:
//   clock, reset                 - system clock, asynchronous active-high reset
//   key, key_valid               - keypad code and its one-cycle qualifier
//   alarm_button, time_button    - one-cycle commit strobes
//   one_second                   - 1 Hz tick
//   key_ms_hr..key_ls_min        - entered digits
//   load_new_alarm/load_new_time - one-cycle load strobes
//   entry_active                 - high while collecting digits
//   entry_error                  - one-cycle strobe on a rejected commit
module key_entry_ctrl
    import key_entry_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    input  logic       one_second,
    output logic [3:0] key_ms_hr,
    output logic [3:0] key_ls_hr,
    output logic [3:0] key_ms_min,
    output logic [3:0] key_ls_min,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       entry_active,
    output logic       entry_error
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] digit_count;
    logic [3:0] timeout_cnt;
    logic       any_button;
    logic       accept;
    logic       commit_ok;
    logic       tick_expire;
    logic       buf_clear;
    logic       time_valid;

    key_shift_reg u_buf (
        .clock      (clock),
        .reset      (reset),
        .shift_en   (accept),
        .clear      (buf_clear),
        .key        (key),
        .ms_hr      (key_ms_hr),
        .ls_hr      (key_ls_hr),
        .ms_min     (key_ms_min),
        .ls_min     (key_ls_min),
        .time_valid (time_valid)
    );

    // Priority in ENTRY: button > digit > timeout tick. Buttons are ignored
    // in IDLE, so a digit arriving with a button there is still taken.
    always_comb begin
        any_button  = alarm_button || time_button;
        accept      = key_valid && (key <= MAX_DIGIT)
                   && ((state == IDLE) || ((state == ENTRY) && !any_button));
        commit_ok   = (digit_count == FULL_DIGITS) && time_valid
                   && !(alarm_button && time_button);
        tick_expire = (state == ENTRY) && !any_button && !accept && one_second
                   && ((timeout_cnt + 4'd1) == TIMEOUT_SECS);
        buf_clear   = (state == LOAD_ALARM) || (state == LOAD_TIME)
                   || (state == ERROR) || tick_expire;

        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ENTRY;
            end
            ENTRY: begin
                if (any_button)
                    state_nxt = !commit_ok ? ERROR
                              : (alarm_button ? LOAD_ALARM : LOAD_TIME);
                else if (tick_expire)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are registered copies of the next-state decode, so each one is
    // high exactly while the FSM sits in its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            digit_count    <= '0;
            timeout_cnt    <= '0;
            load_new_alarm <= 1'b0;
            load_new_time  <= 1'b0;
            entry_active   <= 1'b0;
            entry_error    <= 1'b0;
        end else begin
            state          <= state_nxt;
            load_new_alarm <= (state_nxt == LOAD_ALARM);
            load_new_time  <= (state_nxt == LOAD_TIME);
            entry_active   <= (state_nxt == ENTRY);
            entry_error    <= (state_nxt == ERROR);
            if (state_nxt != ENTRY) begin
                digit_count <= '0;
                timeout_cnt <= '0;
            end else if (accept) begin
                timeout_cnt <= '0;
                if (digit_count != FULL_DIGITS)
                    digit_count <= digit_count + 3'd1;
            end else if (one_second) begin
                timeout_cnt <= timeout_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
module tb_key_entry_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key = '0;
    logic       key_valid = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
    logic       load_new_alarm, load_new_time, entry_active, entry_error;
    logic [15:0] obs_buf;
    logic [7:0]  obs_all;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: buffer kept as a decimal number 0..9999.
    int m_buf, m_cnt, m_secs, m_strobe; // strobe: 0 none, 1 alarm, 2 time, 3 error
    bit m_entry;

    key_entry_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .key            (key),
        .key_valid      (key_valid),
        .alarm_button   (alarm_button),
        .time_button    (time_button),
        .one_second     (one_second),
        .key_ms_hr      (key_ms_hr),
        .key_ls_hr      (key_ls_hr),
        .key_ms_min     (key_ms_min),
        .key_ls_min     (key_ls_min),
        .load_new_alarm (load_new_alarm),
        .load_new_time  (load_new_time),
        .entry_active   (entry_active),
        .entry_error    (entry_error)
    );

    always #5 clock = ~clock;

    assign obs_buf = {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
    assign obs_all = {obs_buf != 16'h0, load_new_alarm, load_new_time, entry_active, entry_error, 3'b000};

    function automatic logic [15:0] bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic drive(input bit kv, input logic [3:0] k, input bit ab, input bit tb, input bit os);
        key_valid = kv; key = k; alarm_button = ab; time_button = tb; one_second = os;
        @(posedge clock); #1;
        key_valid = 0; alarm_button = 0; time_button = 0; one_second = 0;
    endtask

    task automatic keys4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        drive(1, a, 0, 0, 0); drive(1, b, 0, 0, 0); drive(1, c, 0, 0, 0); drive(1, d, 0, 0, 0);
    endtask

    task automatic model_step(input bit kv, input int k, input bit ab, input bit tb, input bit os);
        bit digit;
        digit = kv && (k <= 9);
        if (m_strobe != 0) begin
            m_strobe = 0; m_buf = 0; m_cnt = 0; m_secs = 0; m_entry = 0;
        end else if (!m_entry) begin
            if (digit) begin m_buf = k; m_cnt = 1; m_secs = 0; m_entry = 1; end
        end else if (ab || tb) begin
            m_entry = 0;
            if ((ab && tb) || m_cnt < 4 || (m_buf / 100) > 23 || (m_buf % 100) > 59) m_strobe = 3;
            else m_strobe = ab ? 1 : 2;
        end else if (digit) begin
            m_buf = (m_buf * 10 + k) % 10000; m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4; m_secs = 0;
        end else if (os) begin
            m_secs++;
            if (m_secs == 10) begin m_buf = 0; m_cnt = 0; m_secs = 0; m_entry = 0; end
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL reset_async: got %b want %b", obs_all, 8'h0); end
        @(posedge clock); #1;
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL reset_held: got %b want %b", obs_all, 8'h0); end
        reset = 1'b0;
        drive(0, 0, 1, 1, 1);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL reset_release: got %b want %b", obs_all, 8'h0); end
    endtask

    task automatic test_alarm_load;
        drive(1, 1, 0, 0, 0);
        n_cmp++; if ({entry_active, obs_buf} !== {1'b1, 16'h0001}) begin n_bad++; $display("FAIL first_digit: got %b/%h want 1/0001", entry_active, obs_buf); end
        drive(1, 2, 0, 0, 0); drive(1, 3, 0, 0, 0); drive(1, 0, 0, 0, 0);
        n_cmp++; if (obs_buf !== 16'h1230) begin n_bad++; $display("FAIL alarm_shift: got %h want 1230", obs_buf); end
        drive(0, 0, 1, 0, 0);
        n_cmp++; if ({load_new_alarm, load_new_time, entry_error, entry_active} !== 4'b1000) begin n_bad++; $display("FAIL alarm_strobe: got %b want 1000", {load_new_alarm, load_new_time, entry_error, entry_active}); end
        n_cmp++; if (obs_buf !== 16'h1230) begin n_bad++; $display("FAIL alarm_buf_hold: got %h want 1230", obs_buf); end
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL alarm_after: got %b want %b", obs_all, 8'h0); end
    endtask

    task automatic test_time_error;
        keys4(2, 4, 0, 0);
        drive(0, 0, 0, 1, 0);
        n_cmp++; if ({entry_error, load_new_time, load_new_alarm} !== 3'b100) begin n_bad++; $display("FAIL bad_time_err: got %b want 100", {entry_error, load_new_time, load_new_alarm}); end
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL bad_time_after: got %b want %b", obs_all, 8'h0); end
    endtask

    task automatic test_timeout;
        bit strobed;
        strobed = 0;
        drive(1, 0, 0, 0, 0); drive(1, 9, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 1);
            strobed |= load_new_alarm | load_new_time | entry_error;
        end
        n_cmp++; if ({entry_active, obs_buf} !== {1'b1, 16'h0009}) begin n_bad++; $display("FAIL tick9_hold: got %b/%h want 1/0009", entry_active, obs_buf); end
        drive(0, 0, 0, 0, 1);
        strobed |= load_new_alarm | load_new_time | entry_error;
        n_cmp++; if ({entry_active, obs_buf} !== 17'h0) begin n_bad++; $display("FAIL tick10_idle: got %b/%h want 0/0000", entry_active, obs_buf); end
        // digit after 9 ticks restarts the count
        drive(1, 0, 0, 0, 0); drive(1, 9, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 1);
            strobed |= load_new_alarm | load_new_time | entry_error;
        end
        drive(1, 5, 0, 0, 1);
        n_cmp++; if ({entry_active, obs_buf} !== {1'b1, 16'h0095}) begin n_bad++; $display("FAIL key_vs_tick: got %b/%h want 1/0095", entry_active, obs_buf); end
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 0, 0, 1);
            strobed |= load_new_alarm | load_new_time | entry_error;
        end
        n_cmp++; if (entry_active !== 1'b1) begin n_bad++; $display("FAIL restart_hold: got %b want 1", entry_active); end
        drive(0, 0, 0, 0, 1);
        strobed |= load_new_alarm | load_new_time | entry_error;
        n_cmp++; if ({entry_active, obs_buf} !== 17'h0) begin n_bad++; $display("FAIL restart_idle: got %b/%h want 0/0000", entry_active, obs_buf); end
        n_cmp++; if (strobed !== 1'b0) begin n_bad++; $display("FAIL timeout_strobe: got %b want 0", strobed); end
    endtask

    task automatic test_overflow;
        drive(1, 5, 0, 0, 0); drive(1, 1, 0, 0, 0);
        keys4(0, 4, 5, 9);
        drive(0, 0, 0, 1, 0);
        n_cmp++; if ({load_new_time, load_new_alarm, entry_error} !== 3'b100) begin n_bad++; $display("FAIL overflow_strobe: got %b want 100", {load_new_time, load_new_alarm, entry_error}); end
        n_cmp++; if (obs_buf !== 16'h0459) begin n_bad++; $display("FAIL overflow_buf: got %h want 0459", obs_buf); end
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL overflow_after: got %b want %b", obs_all, 8'h0); end
    endtask

    task automatic test_both_buttons;
        keys4(1, 1, 1, 1);
        drive(0, 0, 1, 1, 0);
        n_cmp++; if ({entry_error, load_new_alarm, load_new_time} !== 3'b100) begin n_bad++; $display("FAIL both_buttons: got %b want 100", {entry_error, load_new_alarm, load_new_time}); end
        drive(0, 0, 0, 0, 0);
        drive(1, 11, 0, 0, 0);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL code11_idle: got %b want %b", obs_all, 8'h0); end
        drive(1, 3, 0, 0, 0); drive(1, 12, 0, 0, 0);
        n_cmp++; if ({entry_active, obs_buf} !== {1'b1, 16'h0003}) begin n_bad++; $display("FAIL code12_entry: got %b/%h want 1/0003", entry_active, obs_buf); end
        drive(0, 0, 1, 0, 0);
        n_cmp++; if ({entry_error, load_new_alarm} !== 2'b10) begin n_bad++; $display("FAIL short_commit: got %b want 10", {entry_error, load_new_alarm}); end
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_button_vs_key;
        keys4(1, 2, 3, 4);
        drive(1, 7, 1, 0, 1);
        n_cmp++; if ({load_new_alarm, obs_buf} !== {1'b1, 16'h1234}) begin n_bad++; $display("FAIL button_wins: got %b/%h want 1/1234", load_new_alarm, obs_buf); end
        drive(1, 8, 0, 1, 0);
        n_cmp++; if ({load_new_time, load_new_alarm, entry_active, obs_buf} !== 19'h0) begin n_bad++; $display("FAIL load_drops: got %b%b%b/%h want 000/0000", load_new_time, load_new_alarm, entry_active, obs_buf); end
    endtask

    task automatic test_reset_in_load;
        keys4(1, 2, 3, 0);
        drive(0, 0, 1, 0, 0);
        n_cmp++; if (load_new_alarm !== 1'b1) begin n_bad++; $display("FAIL pre_reset_load: got %b want 1", load_new_alarm); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL reset_in_load: got %b want %b", obs_all, 8'h0); end
        @(posedge clock); #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        n_cmp++; if (obs_all !== 8'h0) begin n_bad++; $display("FAIL post_reset: got %b want %b", obs_all, 8'h0); end
        drive(1, 7, 0, 0, 0);
        n_cmp++; if ({entry_active, obs_buf} !== {1'b1, 16'h0007}) begin n_bad++; $display("FAIL post_reset_idle: got %b/%h want 1/0007", entry_active, obs_buf); end
    endtask

    task automatic test_random;
        bit kv, ab, tb, os, quiet;
        logic [3:0] k;
        #2 reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        m_buf = 0; m_cnt = 0; m_secs = 0; m_strobe = 0; m_entry = 0;
        for (int i = 0; i < 3000; i++) begin
            quiet = ((i / 200) % 2) == 1;
            kv = quiet ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            k  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            ab = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 15) == 0);
            tb = quiet ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 15) == 0);
            os = ($urandom_range(0, 1) == 0);
            model_step(kv, int'(k), ab, tb, os);
            drive(kv, k, ab, tb, os);
            n_cmp++; if (obs_buf !== bcd4(m_buf)) begin n_bad++; $display("FAIL rand_buf @%0d: got %h want %h", i, obs_buf, bcd4(m_buf)); end
            n_cmp++; if ({load_new_alarm, load_new_time, entry_error, entry_active} !== {m_strobe == 1, m_strobe == 2, m_strobe == 3, m_entry})
                begin n_bad++; $display("FAIL rand_ctl @%0d: got %b want %b", i, {load_new_alarm, load_new_time, entry_error, entry_active}, {m_strobe == 1, m_strobe == 2, m_strobe == 3, m_entry}); end
        end
    endtask

    initial begin
        test_reset;
        test_alarm_load;
        test_time_error;
        test_timeout;
        test_overflow;
        test_both_buttons;
        test_button_vs_key;
        test_reset_in_load;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
